// File: rtl/cpu_tb_lcd.sv
// 8-bit accumulator CPU running a fixed ROM, shown as two hex characters on a 4-bit character LCD.
// Optional: define CPU_TB_LCD_PREFIX_EN to print "0x" before the hex digits on every refresh.
module cpu_tb_lcd #(
  parameter int unsigned CPU_DIV = 50000000,
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_E     = 12,
  parameter int unsigned T_NIB   = 50,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        LCD_E,
  output logic        LCD_RW,
  output logic        LCD_RS,
  output logic [11:8] SF_D
);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_CFG, S_ADDR, S_PREFIX, S_CH_HI, S_CH_LO
  } lcd_state_e;

  typedef enum logic [2:0] {
    PH_IDLE, PH_SETUP, PH_E, PH_HOLD, PH_NIB, PH_WAIT
  } phase_e;

  function automatic logic [7:0] rom(input logic [3:0] addr);
    case (addr)
      4'd0:    rom = 8'h15;
      4'd1:    rom = 8'h60;
      4'd2:    rom = 8'h31;
      4'd3:    rom = 8'h51;
      4'd4:    rom = 8'h60;
      4'd5:    rom = 8'h70;
      default: rom = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // ---------------- CPU ----------------
  logic [31:0] step_q;
  logic [3:0]  pc_q;
  logic [7:0]  acc_q;
  logic [7:0]  disp_q;
  logic        halted_q;
  logic [7:0]  instr;
  logic [7:0]  imm;

  assign instr = rom(pc_q);
  assign imm   = {4'h0, instr[3:0]};

  // NOTE: all state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      step_q   <= '0;
      pc_q     <= '0;
      acc_q    <= '0;
      disp_q   <= '0;
      halted_q <= 1'b0;
    end else if (step_q == CPU_DIV - 1) begin
      step_q <= '0;
      if (!halted_q) begin
        pc_q <= pc_q + 4'd1;
        case (instr[7:4])
          4'h1: acc_q <= imm;
          4'h2: acc_q <= acc_q + imm;
          4'h3: acc_q <= acc_q - imm;
          4'h4: pc_q  <= instr[3:0];
          4'h5: if (acc_q != 8'h00) pc_q <= instr[3:0];
          4'h6: disp_q <= acc_q;
          4'h7: begin
            halted_q <= 1'b1;
            pc_q     <= pc_q;
          end
          default: ;
        endcase
      end
    end else begin
      step_q <= step_q + 32'd1;
    end
  end

  // ---------------- LCD driver ----------------
  lcd_state_e  state_q;
  phase_e      ph_q;
  logic [1:0]  idx_q;
  logic [31:0] cnt_q;
  logic [31:0] wait_q;
  logic [7:0]  byte_q;
  logic        is_byte_q;
  logic        lo_q;
  logic [7:0]  shown_q;
  logic        e_q;
  logic        rs_q;
  logic [3:0]  sf_q;

  logic        cmd_go;
  logic [7:0]  cmd_byte;
  logic        cmd_is_byte;
  logic        cmd_rs;
  logic [31:0] cmd_wait;
  lcd_state_e  nxt_state;
  logic [1:0]  nxt_idx;

  // Next item to hand to the nibble engine; nibble-only commands carry their value in the upper half.
  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    cmd_go      = 1'b1;
    cmd_byte    = 8'h00;
    cmd_is_byte = 1'b1;
    cmd_rs      = 1'b0;
    cmd_wait    = T_CMD;
    nxt_state   = state_q;
    nxt_idx     = idx_q + 2'd1;
    case (state_q)
      S_PWRUP, S_INIT: begin
        cmd_go      = (state_q == S_INIT) || (cnt_q == T_PWRUP - 1);
        cmd_is_byte = 1'b0;
        cmd_byte    = (idx_q == 2'd3) ? 8'h20 : 8'h30;
        cmd_wait    = (idx_q == 2'd0) ? T_CMD * 100 :
                      (idx_q == 2'd1) ? T_CMD * 3 : T_CMD;
        nxt_state   = (idx_q == 2'd3) ? S_CFG : S_INIT;
      end
      S_CFG: begin
        case (idx_q)
          2'd0:    cmd_byte = 8'h28;
          2'd1:    cmd_byte = 8'h06;
          2'd2:    cmd_byte = 8'h0C;
          default: cmd_byte = 8'h01;
        endcase
        cmd_wait  = (idx_q == 2'd3) ? T_CLR : T_CMD;
        nxt_state = (idx_q == 2'd3) ? S_ADDR : S_CFG;
      end
      S_ADDR: begin
        cmd_byte = 8'h80;
        nxt_idx  = 2'd0;
`ifdef CPU_TB_LCD_PREFIX_EN
        nxt_state = S_PREFIX;
`else
        nxt_state = S_CH_HI;
`endif
      end
      S_PREFIX: begin
        cmd_rs    = 1'b1;
        cmd_byte  = (idx_q == 2'd0) ? 8'h30 : 8'h78;
        nxt_state = (idx_q == 2'd0) ? S_PREFIX : S_CH_HI;
      end
      S_CH_HI: begin
        cmd_rs    = 1'b1;
        cmd_byte  = hex_ascii(shown_q[7:4]);
        nxt_state = S_CH_LO;
      end
      S_CH_LO: begin
        cmd_rs    = 1'b1;
        cmd_byte  = hex_ascii(shown_q[3:0]);
        nxt_state = S_ADDR;
      end
      default: nxt_state = S_PWRUP;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_PWRUP;
      ph_q      <= PH_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      byte_q    <= '0;
      is_byte_q <= 1'b0;
      lo_q      <= 1'b0;
      shown_q   <= '0;
      e_q       <= 1'b0;
      rs_q      <= 1'b0;
      sf_q      <= '0;
    end else begin
      case (ph_q)
        PH_IDLE: begin
          if (!cmd_go) begin
            cnt_q <= cnt_q + 32'd1;
          end else begin
            state_q   <= nxt_state;
            idx_q     <= nxt_idx;
            byte_q    <= cmd_byte;
            is_byte_q <= cmd_is_byte;
            lo_q      <= 1'b0;
            rs_q      <= cmd_rs;
            sf_q      <= cmd_byte[7:4];
            wait_q    <= cmd_wait;
            cnt_q     <= '0;
            ph_q      <= PH_SETUP;
            // Latch disp once per refresh so both characters come from the same value.
            if (state_q == S_ADDR) shown_q <= disp_q;
          end
        end
        PH_SETUP: begin
          if (cnt_q == 32'd1) begin
            e_q   <= 1'b1;
            cnt_q <= '0;
            ph_q  <= PH_E;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        PH_E: begin
          if (cnt_q == T_E - 1) begin
            e_q   <= 1'b0;
            cnt_q <= '0;
            ph_q  <= PH_HOLD;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        PH_HOLD: ph_q <= PH_NIB;
        PH_NIB: begin
          if (cnt_q == T_NIB - 1) begin
            cnt_q <= '0;
            if (is_byte_q && !lo_q) begin
              lo_q <= 1'b1;
              sf_q <= byte_q[3:0];
              ph_q <= PH_SETUP;
            end else begin
              ph_q <= PH_WAIT;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        PH_WAIT: begin
          if (cnt_q == wait_q - 1) begin
            cnt_q <= '0;
            ph_q  <= PH_IDLE;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: ph_q <= PH_IDLE;
      endcase
    end
  end

  assign LCD_E  = e_q;
  assign LCD_RW = 1'b0;
  assign LCD_RS = rs_q;
  assign SF_D   = sf_q;

endmodule

// File: tb/tb_cpu_tb_lcd.sv
// Bench for cpu_tb_lcd: ISA-level CPU model plus decode of the LCD nibble stream captured on E falling edges.
module tb_cpu_tb_lcd;

  localparam int D       = 1000;
  localparam int T_PWRUP = 100;
  localparam int T_E     = 3;
  localparam int T_NIB   = 4;
  localparam int T_CMD   = 10;
  localparam int T_CLR   = 40;
  localparam int RUN1    = 20000;
`ifdef CPU_TB_LCD_PREFIX_EN
  localparam int REF_BYTES = 5;
`else
  localparam int REF_BYTES = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_e, lcd_rw, lcd_rs;
  logic [3:0] sf_d;

  cpu_tb_lcd #(
    .CPU_DIV(D), .T_PWRUP(T_PWRUP), .T_E(T_E), .T_NIB(T_NIB), .T_CMD(T_CMD), .T_CLR(T_CLR)
  ) dut (
    .CLK(clk), .RST(rst), .LCD_E(lcd_e), .LCD_RW(lcd_rw), .LCD_RS(lcd_rs), .SF_D(sf_d)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Capture of every nibble strobe: value, RS, RW, times and pulse width.
  logic [3:0] nib_q[$];
  logic       rs_q[$];
  logic       rw_q[$];
  int         fall_t[$];
  int         rise_t[$];
  int         width_q[$];

  initial begin
    logic e_prev;
    int   width;
    e_prev = 1'b0;
    width  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nib_q.delete(); rs_q.delete(); rw_q.delete();
        fall_t.delete(); rise_t.delete(); width_q.delete();
        e_prev = 1'b0;
        width  = 0;
      end else begin
        if (lcd_e && !e_prev) rise_t.push_back(cyc);
        if (lcd_e) width++;
        if (!lcd_e && e_prev) begin
          nib_q.push_back(sf_d);
          rs_q.push_back(lcd_rs);
          rw_q.push_back(lcd_rw);
          fall_t.push_back(cyc);
          width_q.push_back(width);
          width = 0;
        end
        e_prev = lcd_e;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[n];
  endfunction

  task automatic check_outputs_reset(input string ph);
    check({ph, "_lcd_e"},  {31'd0, lcd_e},  32'd0);
    check({ph, "_lcd_rw"}, {31'd0, lcd_rw}, 32'd0);
    check({ph, "_lcd_rs"}, {31'd0, lcd_rs}, 32'd0);
    check({ph, "_sf_d"},   {28'd0, sf_d},   32'd0);
  endtask

  // Power-up timing plus the 4 init nibbles and 4 config bytes, all commands.
  task automatic check_boot(input string ph);
    int exp_nib[12];
    exp_nib = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};
    if (rise_t.size() == 0) begin
      check({ph, "_first_rise_seen"}, 32'd0, 32'd1);
    end else begin
      check({ph, "_first_rise_in_window"},
            {31'd0, (rise_t[0] >= T_PWRUP + 1) && (rise_t[0] <= T_PWRUP + 3)}, 32'd1);
    end
    if (nib_q.size() < 13 || rise_t.size() < 13) begin
      check({ph, "_boot_nibbles"}, nib_q.size(), 32'd13);
    end else begin
      for (int i = 0; i < 12; i++) begin
        check($sformatf("%s_nib%0d", ph, i), {28'd0, nib_q[i]}, exp_nib[i]);
        check($sformatf("%s_nib%0d_rs", ph, i), {31'd0, rs_q[i]}, 32'd0);
      end
      check({ph, "_clear_gap_ok"}, {31'd0, (rise_t[12] - fall_t[11]) >= T_CLR}, 32'd1);
    end
  endtask

  // ISA-level reference model.
  int       rom[16];
  int       m_pc, m_acc, m_disp;
  bit       m_halt;
  int       hist[RUN1 + 1];

  task automatic model_step();
    int op, im;
    if (m_halt) return;
    op = rom[m_pc] / 16;
    im = rom[m_pc] % 16;
    m_pc = (m_pc + 1) % 16;
    case (op)
      1: m_acc = im;
      2: m_acc = (m_acc + im) % 256;
      3: m_acc = (m_acc - im + 256) % 256;
      4: m_pc = im;
      5: if (m_acc != 0) m_pc = im;
      6: m_disp = m_acc;
      7: begin m_halt = 1; m_pc = (m_pc + 15) % 16; end
      default: ;
    endcase
  endtask

  initial begin
    int p, t, exp_v, n_ref, last_v;
    bit saw05, ok;
    logic [7:0] b_addr, b_hi, b_lo;

    for (int i = 0; i < 16; i++) rom[i] = 0;
    rom[0] = 8'h15; rom[1] = 8'h60; rom[2] = 8'h31;
    rom[3] = 8'h51; rom[4] = 8'h60; rom[5] = 8'h70;
    m_pc = 0; m_acc = 0; m_disp = 0; m_halt = 0;

    // Reset state.
    repeat ($urandom_range(2, 6)) @(negedge clk);
    check_outputs_reset("reset");
    check("reset_pc",   {28'd0, dut.pc_q}, 32'd0);
    check("reset_disp", {24'd0, dut.disp_q}, 32'd0);

    // Run 1: CPU program against the model, LCD stream captured in the background.
    rst = 1'b0;
    hist[0] = 0;
    for (int c = 1; c <= RUN1; c++) begin
      @(negedge clk);
      if (c % D == 0) begin
        model_step();
        check($sformatf("pc_step%0d", c / D), {28'd0, dut.pc_q}, m_pc);
        check($sformatf("disp_step%0d", c / D), {24'd0, dut.disp_q}, m_disp);
      end
      hist[c] = m_disp;
    end
    check("halted_pc", {28'd0, dut.pc_q}, 32'd5);
    check("halted_disp", {24'd0, dut.disp_q}, 32'd0);

    check_boot("boot1");
    foreach (width_q[i]) check($sformatf("e_width%0d", i), width_q[i], T_E);
    foreach (rw_q[i])    check($sformatf("rw%0d", i), {31'd0, rw_q[i]}, 32'd0);

    // Decode refresh passes following the boot sequence.
    p = 12; n_ref = 0; saw05 = 0; last_v = -1;
    while (p + 2 * REF_BYTES <= nib_q.size()) begin
      b_addr = {nib_q[p], nib_q[p + 1]};
      check($sformatf("ref%0d_addr", n_ref), {24'd0, b_addr}, 32'h80);
      check($sformatf("ref%0d_addr_rs", n_ref), {30'd0, rs_q[p], rs_q[p + 1]}, 32'd0);
`ifdef CPU_TB_LCD_PREFIX_EN
      check($sformatf("ref%0d_pfx0", n_ref), {24'd0, nib_q[p + 2], nib_q[p + 3]}, 32'h30);
      check($sformatf("ref%0d_pfx1", n_ref), {24'd0, nib_q[p + 4], nib_q[p + 5]}, 32'h78);
`endif
      b_hi = {nib_q[p + 2 * REF_BYTES - 4], nib_q[p + 2 * REF_BYTES - 3]};
      b_lo = {nib_q[p + 2 * REF_BYTES - 2], nib_q[p + 2 * REF_BYTES - 1]};
      check($sformatf("ref%0d_char_rs", n_ref),
            {28'd0, rs_q[p + 2 * REF_BYTES - 4], rs_q[p + 2 * REF_BYTES - 3],
             rs_q[p + 2 * REF_BYTES - 2], rs_q[p + 2 * REF_BYTES - 1]}, 32'hF);
      // disp is sampled a few cycles before the 0x80 strobe; allow a small window around it.
      t = fall_t[p];
      exp_v = hist[t - 6];
      ok = 0;
      for (int w = t - 10; w <= t - 2; w++)
        if (!ok && b_hi == hex_char(hist[w][7:4]) && b_lo == hex_char(hist[w][3:0])) begin
          ok = 1;
          exp_v = hist[w];
        end
      check($sformatf("ref%0d_chars", n_ref), {16'd0, b_hi, b_lo},
            {16'd0, hex_char(exp_v[7:4]), hex_char(exp_v[3:0])});
      if (exp_v == 5) saw05 = 1;
      last_v = exp_v;
      n_ref++;
      p += 2 * REF_BYTES;
    end
    check("refresh_count_nonzero", {31'd0, n_ref > 10}, 32'd1);
    check("saw_disp_05", {31'd0, saw05}, 32'd1);
    check("final_disp_00", last_v, 32'd0);

    // Asynchronous reset in the middle of a refresh, then a full restart.
    repeat ($urandom_range(50, 400)) @(negedge clk);
    #($urandom_range(1, 3));
    rst = 1'b1;
    #1;
    check_outputs_reset("midrun");
    check("midrun_pc", {28'd0, dut.pc_q}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (1600) @(negedge clk);
    check_boot("boot2");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
